// File: rtl/mem_op_sequencer.sv
// -----------------------------------------------------------------------------
// mem_op_sequencer
//
// Hardwired control sequencer for the memory-class instructions ld, ldi and
// st. It steps through a shared fetch (F0..F2) and a per-opcode execute phase
// (E3..E7), and raises the datapath control strobes for each step. Every RAM
// access (the fetch read, the ld operand read and the st write) can be
// stretched by MEM_WAIT extra cycles for slower memories.
//
// Parameters
//   OP_LD / OP_LDI / OP_ST  opcodes found in IR_Data[31:27]
//   ALU_ADD                 ALU code for the Rb + C effective-address add
//   MEM_WAIT                extra cycles per memory access, 0..15
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   asynchronous, active-high; forces IDLE, all outputs 0
//   run                  in   1 = fetch/execute continuously, 0 = stop at the
//                             next instruction boundary
//   IR_Data[31:0]        in   instruction register contents
//   PC_select            out  PC onto bus
//   MAR_enable           out  load MAR from bus
//   PC_increment_enable  out  PC <= PC + 1
//   read                 out  memory read; MDR input mux selects memory
//   write                out  memory write (address from MAR, data from MDR)
//   MDR_enable           out  load MDR (from memory when read=1, else from bus)
//   MDR_select           out  MDR onto bus
//   IR_enable            out  load IR from bus
//   Gra / Grb            out  select the Ra / Rb register field
//   BAout                out  base-address out (R0 reads as 0)
//   Y_enable             out  load Y from bus
//   c_select             out  sign-extended C field onto bus
//   alu_instruction[4:0] out  ALU opcode (ALU_ADD in E4, otherwise 0)
//   Z_enable             out  load Z from ALU
//   Z_LO_select          out  Z_LO onto bus
//   r_enable             out  write the selected register from bus
//   busy                 out  1 in every state except IDLE
//   done                 out  1-cycle pulse on the final cycle of a legal instruction
//   illegal              out  1-cycle pulse in E3 when the opcode is not ld/ldi/st
// -----------------------------------------------------------------------------
module mem_op_sequencer #(
  parameter logic [4:0]  OP_LD    = 5'b00000,
  parameter logic [4:0]  OP_LDI   = 5'b00001,
  parameter logic [4:0]  OP_ST    = 5'b00010,
  parameter logic [4:0]  ALU_ADD  = 5'b00000,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        MAR_enable,
  output logic        PC_increment_enable,
  output logic        read,
  output logic        write,
  output logic        MDR_enable,
  output logic        MDR_select,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        Y_enable,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        Z_enable,
  output logic        Z_LO_select,
  output logic        r_enable,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_E3,
    S_E4,
    S_E5,
    S_E6,
    S_E7
  } state_t;

  typedef enum logic [1:0] {
    OPC_LD,
    OPC_LDI,
    OPC_ST,
    OPC_BAD
  } opc_t;

  // Wait counter is 4 bits wide, so MEM_WAIT is meaningful in 0..15.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  opc_t       op_q, op_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  opc_t       ir_op;
  logic       wait_first;
  logic       wait_last;
  logic [3:0] wait_inc;
  state_t     boundary_state;

  // Only the opcode field steers the sequencer; the register and constant
  // fields are consumed by the datapath.
  logic ir_unused;
  assign ir_unused = ^IR_Data[26:0];

  // ---------------------------------------------------------------------------
  // Opcode decode. IR is loaded on the edge that leaves F2, so IR_Data is
  // stable for the whole of E3; the class is captured into op_q there and
  // E4..E7 steer from the captured copy.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (IR_Data[31:27] == OP_LD) begin
      ir_op = OPC_LD;
    end else if (IR_Data[31:27] == OP_LDI) begin
      ir_op = OPC_LDI;
    end else if (IR_Data[31:27] == OP_ST) begin
      ir_op = OPC_ST;
    end else begin
      ir_op = OPC_BAD;
    end
  end

  // Memory-access stretching: a held state is entered with the counter at 0
  // and leaves when it reaches WAIT_LAST. The increment saturates so the
  // counter can never run past WAIT_LAST.
  assign wait_first = (wait_cnt_q == 4'd0);
  assign wait_last  = (wait_cnt_q == WAIT_LAST);
  assign wait_inc   = wait_last ? wait_cnt_q : (wait_cnt_q + 4'd1);

  // Where to go after the last cycle of an instruction (done or illegal).
  // A run deassert mid-instruction only takes effect here.
  assign boundary_state = run ? S_F0 : S_IDLE;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OPC_LD;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_F0;
        end
      end

      S_F0: begin
        state_d    = S_F1;
        wait_cnt_d = 4'd0;
      end

      S_F1: begin
        if (wait_last) begin
          state_d = S_F2;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_F2: begin
        state_d = S_E3;
      end

      S_E3: begin
        op_d = ir_op;
        if (ir_op == OPC_BAD) begin
          state_d = boundary_state;
        end else begin
          state_d = S_E4;
        end
      end

      S_E4: begin
        state_d = S_E5;
      end

      S_E5: begin
        if (op_q == OPC_LDI) begin
          state_d = boundary_state;
        end else begin
          state_d    = S_E6;
          wait_cnt_d = 4'd0;
        end
      end

      S_E6: begin
        if (op_q == OPC_ST) begin
          // st moves Ra into MDR in a single cycle; the write is stretched in E7.
          state_d    = S_E7;
          wait_cnt_d = 4'd0;
        end else if (wait_last) begin
          state_d    = S_E7;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_E7: begin
        if (op_q == OPC_LD) begin
          state_d = boundary_state;
        end else if (wait_last) begin
          state_d = boundary_state;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control strobes: Moore decode of the state register (plus wait counter
  // for the stretched accesses). Because they come straight from the
  // async-reset flops, a reset mid-access drops read/write at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    PC_select           = 1'b0;
    MAR_enable          = 1'b0;
    PC_increment_enable = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    MDR_enable          = 1'b0;
    MDR_select          = 1'b0;
    IR_enable           = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    BAout               = 1'b0;
    Y_enable            = 1'b0;
    c_select            = 1'b0;
    alu_instruction     = 5'b00000;
    Z_enable            = 1'b0;
    Z_LO_select         = 1'b0;
    r_enable            = 1'b0;
    done                = 1'b0;
    illegal             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
      end

      S_F0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end

      S_F1: begin
        // Read held for the whole access; PC bumps once on entry and MDR
        // captures only when the memory data is ready.
        read                = 1'b1;
        PC_increment_enable = wait_first;
        MDR_enable          = wait_last;
      end

      S_F2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end

      S_E3: begin
        if (ir_op == OPC_BAD) begin
          illegal = 1'b1;
        end else begin
          Grb      = 1'b1;
          BAout    = 1'b1;
          Y_enable = 1'b1;
        end
      end

      S_E4: begin
        c_select        = 1'b1;
        alu_instruction = ALU_ADD;
        Z_enable        = 1'b1;
      end

      S_E5: begin
        Z_LO_select = 1'b1;
        if (op_q == OPC_LDI) begin
          // ldi: the effective address itself is the result.
          Gra      = 1'b1;
          r_enable = 1'b1;
          done     = 1'b1;
        end else begin
          MAR_enable = 1'b1;
        end
      end

      S_E6: begin
        if (op_q == OPC_ST) begin
          // read stays low, so MDR loads Ra from the bus.
          Gra        = 1'b1;
          MDR_enable = 1'b1;
        end else begin
          read       = 1'b1;
          MDR_enable = wait_last;
        end
      end

      S_E7: begin
        if (op_q == OPC_LD) begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
          done       = 1'b1;
        end else begin
          write = 1'b1;
          done  = wait_last;
        end
      end

      default: begin
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule
